// File: rtl/bram_burst_reader_if.sv
// Bundle of command, BRAM-port and stream signals for bram_burst_reader.
// The master modport is the reader's own view (it drives the BRAM port and
// the stream); the slave modport is the view of whatever surrounds it.
// Optional macro BRAM_BURST_READER_CHECKSUM_EN adds checksum_out.
interface bram_burst_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18
) ();
    // Command side
    logic                  start_in;
    logic [ADDR_WIDTH-1:0] base_addr_in;
    logic [ADDR_WIDTH:0]   len_in;
    logic                  busy_out;
    logic                  done_out;
    // BRAM read port
    logic [ADDR_WIDTH-1:0] bram_addr_out;
    logic                  bram_en_out;
    logic                  bram_regce_out;
    logic [DATA_WIDTH-1:0] bram_dout_in;
    // Output stream
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_in;
    logic                  last_out;
`ifdef BRAM_BURST_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_out;

    modport master (
        input  start_in, base_addr_in, len_in, bram_dout_in, ready_in,
        output busy_out, done_out, bram_addr_out, bram_en_out, bram_regce_out,
        output data_out, valid_out, last_out, checksum_out
    );
    modport slave (
        output start_in, base_addr_in, len_in, bram_dout_in, ready_in,
        input  busy_out, done_out, bram_addr_out, bram_en_out, bram_regce_out,
        input  data_out, valid_out, last_out, checksum_out
    );
`else
    modport master (
        input  start_in, base_addr_in, len_in, bram_dout_in, ready_in,
        output busy_out, done_out, bram_addr_out, bram_en_out, bram_regce_out,
        output data_out, valid_out, last_out
    );
    modport slave (
        output start_in, base_addr_in, len_in, bram_dout_in, ready_in,
        input  busy_out, done_out, bram_addr_out, bram_en_out, bram_regce_out,
        input  data_out, valid_out, last_out
    );
`endif
endinterface

// File: rtl/bram_burst_reader.sv
// Burst read initiator for a fixed-latency BRAM port.
// Issues sequential reads from a base address, tracks in-flight requests in a
// latency pipe, and buffers returned words in a skid FIFO that feeds a
// valid/ready stream with a last flag. Reads are only issued while the FIFO
// has room for every outstanding word, so the FIFO can never overflow.
// Optional macro BRAM_BURST_READER_CHECKSUM_EN: XOR checksum of the burst.
module bram_burst_reader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 18,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    bram_burst_reader_if.master  bus
);
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = CNT_W + 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                                 state_q, state_d;
    logic                                   busy_q, busy_d;
    logic                                   zdone_q, zdone_d;
    logic                                   en_q, en_d;
    logic                                   en_last_q, en_last_d;
    logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
    logic [LEN_W-1:0]                       remain_q, remain_d;
    logic [READ_LATENCY-1:0]                pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0]                pipe_last_q, pipe_last_d;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]  fifo_data_q, fifo_data_d;
    logic [FIFO_DEPTH-1:0]                  fifo_last_q, fifo_last_d;
    logic [CNT_W-1:0]                       count_q, count_d;
    logic                                   valid_q, valid_d;

    logic                                   pop_s;
    logic                                   push_s;
    logic                                   push_last_s;
    logic                                   credit_ok_s;
    logic                                   start_acc_s;
    logic                                   done_s;
    logic [SUM_W-1:0]                       outstanding_s;
    logic [CNT_W-1:0]                       wr_cnt_s;
    logic [PTR_W-1:0]                       wr_idx_s;

    assign pop_s       = valid_q & bus.ready_in;
    assign push_s      = pipe_vld_q[READ_LATENCY-1];
    assign push_last_s = pipe_last_q[READ_LATENCY-1];

    // Credit check: reads in flight plus buffered words, less the word leaving now.
    always_comb begin
        outstanding_s = SUM_W'(en_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            outstanding_s = outstanding_s + SUM_W'(pipe_vld_q[i]);
        end
        outstanding_s = outstanding_s + SUM_W'(count_q) - SUM_W'(pop_s);
        credit_ok_s   = (outstanding_s < SUM_W'(FIFO_DEPTH));
    end

    // Burst FSM: start acceptance, read issue and completion.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        zdone_d     = 1'b0;
        en_d        = 1'b0;
        en_last_d   = 1'b0;
        addr_d      = addr_q;
        remain_d    = remain_q;
        start_acc_s = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_in && !busy_q) begin
                    start_acc_s = 1'b1;
                    busy_d      = 1'b1;
                    if (bus.len_in == LEN_W'(0)) begin
                        // Empty burst: done pulses with busy for one cycle.
                        zdone_d = 1'b1;
                    end else begin
                        // The first read goes out right away; the FIFO is empty.
                        en_d      = 1'b1;
                        addr_d    = bus.base_addr_in;
                        remain_d  = bus.len_in - LEN_W'(1);
                        en_last_d = (bus.len_in == LEN_W'(1));
                        state_d   = (bus.len_in == LEN_W'(1)) ? ST_DRAIN : ST_ISSUE;
                    end
                end else begin
                    // Drops busy after the single-cycle empty burst.
                    busy_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (credit_ok_s) begin
                    en_d      = 1'b1;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    remain_d  = remain_q - LEN_W'(1);
                    en_last_d = (remain_q == LEN_W'(1));
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (pop_s && fifo_last_q[0]) begin
                    done_s  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Latency pipe: an issue flag (and its last tag) travels with each read.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_last_d    = pipe_last_q;
        pipe_vld_d[0]  = en_q;
        pipe_last_d[0] = en_last_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
        end
    end

    // Skid FIFO as a shift register: slot 0 is always the head of the stream.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_cnt_s    = count_q - CNT_W'(pop_s);
        wr_idx_s    = wr_cnt_s[PTR_W-1:0];
        if (pop_s) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_data_d[i] = fifo_data_q[i+1];
                fifo_last_d[i] = fifo_last_q[i+1];
            end
            // Vacated slots are kept clear so an empty head reads as zero.
            fifo_data_d[FIFO_DEPTH-1] = {DATA_WIDTH{1'b0}};
            fifo_last_d[FIFO_DEPTH-1] = 1'b0;
        end else begin
            fifo_data_d = fifo_data_q;
        end
        if (push_s) begin
            fifo_data_d[wr_idx_s] = bus.bram_dout_in;
            fifo_last_d[wr_idx_s] = push_last_s;
        end else begin
            fifo_last_d = fifo_last_d;
        end
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        valid_d = (count_d != CNT_W'(0));
    end

    // State, request and FIFO registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            zdone_q     <= 1'b0;
            en_q        <= 1'b0;
            en_last_q   <= 1'b0;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            remain_q    <= {LEN_W{1'b0}};
            pipe_vld_q  <= {READ_LATENCY{1'b0}};
            pipe_last_q <= {READ_LATENCY{1'b0}};
            fifo_data_q <= {(FIFO_DEPTH*DATA_WIDTH){1'b0}};
            fifo_last_q <= {FIFO_DEPTH{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            zdone_q     <= zdone_d;
            en_q        <= en_d;
            en_last_q   <= en_last_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.busy_out       = busy_q;
    // Completion must coincide with the last transfer, so it follows ready_in.
    assign bus.done_out       = zdone_q | done_s;
    assign bus.bram_addr_out  = addr_q;
    assign bus.bram_en_out    = en_q;
    assign bus.bram_regce_out = 1'b1;
    assign bus.data_out       = fifo_data_q[0];
    assign bus.valid_out      = valid_q;
    assign bus.last_out       = fifo_last_q[0];

`ifdef BRAM_BURST_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] chk_q, chk_d;

    // Running XOR of transferred words, restarted on every accepted start.
    always_comb begin
        if (start_acc_s) begin
            chk_d = {DATA_WIDTH{1'b0}};
        end else if (pop_s) begin
            chk_d = chk_q ^ fifo_data_q[0];
        end else begin
            chk_d = chk_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            chk_q <= {DATA_WIDTH{1'b0}};
        end else begin
            chk_q <= chk_d;
        end
    end

    // Folds in the word moving this cycle so the final value shows with done_out.
    assign bus.checksum_out = chk_q ^ (pop_s ? fifo_data_q[0] : {DATA_WIDTH{1'b0}});
`endif

endmodule

// File: tb/tb_bram_burst_reader.sv
`timescale 1ns/1ps
module tb_bram_burst_reader;
    localparam int AW = 10;
    localparam int DW = 18;
    localparam int RL = 2;
    localparam int FD = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_burst_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_burst_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    // BRAM model: two-cycle read, content = address + 1
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] bram_s1;
    always @(posedge clk) begin
        if (bus.bram_en_out) bram_s1 <= mem[bus.bram_addr_out];
        bus.bram_dout_in <= bram_s1;
    end

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    int checks = 0;
    int failures = 0;
    int issued = 0, popped = 0, burst_pops = 0, burst_len = 0;
    int cyc = 0, first_cyc = 0, last_cyc = 0;
    bit saw_gap = 0, zlen_window = 0, toggle_mode = 0;
    bit prev_stall = 0, prev_last = 0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] sb_chk = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit cond);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL %s: condition false, expected true", name);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            issued = 0; popped = 0; prev_stall = 0;
        end else begin
            cyc++;
            if (bus.bram_en_out) begin
                issued++;
                check_true("read_expected", addr_q.size() != 0);
                if (addr_q.size() != 0) check("bram_addr", bus.bram_addr_out, addr_q.pop_front());
            end else if (addr_q.size() != 0 && addr_q.size() != burst_len) begin
                saw_gap = 1;
            end
            check_true("credit_limit", (issued - popped) <= FD);
            if (prev_stall) begin
                check("stall_data", bus.data_out, prev_data);
                check("stall_last", bus.last_out, prev_last);
            end
            if (bus.valid_out && bus.ready_in) begin
                check_true("word_expected", exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("data", bus.data_out, e.data);
                    check("last", bus.last_out, e.last);
                    check("done_with_last", bus.done_out, e.last);
                    sb_chk = sb_chk ^ e.data;
`ifdef BRAM_BURST_READER_CHECKSUM_EN
                    if (e.last) check("checksum_at_done", bus.checksum_out, sb_chk);
`endif
                end
                if (burst_pops == 0) first_cyc = cyc;
                last_cyc = cyc;
                popped++;
                burst_pops++;
            end else if (bus.done_out) begin
                check_true("no_spurious_done", zlen_window);
            end
            prev_stall = bus.valid_out && !bus.ready_in;
            prev_data  = bus.data_out;
            prev_last  = bus.last_out;
        end
    end

    // Ready pattern 1,0,0,1 when toggling
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) begin
                bus.ready_in = pat[ph];
                ph = (ph + 1) % 4;
            end
        end
    end

    task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l);
        for (int i = 0; i < int'(l); i++) begin
            exp_t e;
            logic [AW-1:0] a;
            a = AW'(int'(b) + i);
            addr_q.push_back(a);
            e.data = DW'(a) + DW'(1);
            e.last = (i == int'(l) - 1);
            exp_q.push_back(e);
        end
        burst_len  = int'(l);
        burst_pops = 0;
        sb_chk     = '0;
        bus.base_addr_in = b;
        bus.len_in       = l;
        bus.start_in     = 1'b1;
        @(posedge clk);
        #1;
        bus.start_in = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.done_out) begin
                seen = 1;
                break;
            end
        end
        check_true(name, seen);
        @(posedge clk);
        #1;
        check("busy_after_done", bus.busy_out, 1'b0);
        check_true("queues_drained", exp_q.size() == 0 && addr_q.size() == 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  bus.busy_out, 1'b0);
        check({tag, "_done"},  bus.done_out, 1'b0);
        check({tag, "_en"},    bus.bram_en_out, 1'b0);
        check({tag, "_addr"},  bus.bram_addr_out, 10'h000);
        check({tag, "_valid"}, bus.valid_out, 1'b0);
        check({tag, "_last"},  bus.last_out, 1'b0);
        check({tag, "_data"},  bus.data_out, 18'h00000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [DW-1:0] first_word;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 1);
        bus.start_in = 1'b0;
        bus.base_addr_in = '0;
        bus.len_in = '0;
        bus.ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_regce", bus.bram_regce_out, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: base 0x010 len 8, ready high
        bus.ready_in = 1'b1;
        start_burst(10'h010, 11'd8);
        lat = 0;
        first_word = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.valid_out) begin
                lat = k;
                first_word = bus.data_out;
                break;
            end
        end
        check("first_valid_latency", lat, 3);
        check("first_word", first_word, 18'h00011);
        wait_done(40, "done_len8");
        check("consecutive_span", last_cyc - first_cyc, 7);
        check("word_count_len8", burst_pops, 8);
`ifdef BRAM_BURST_READER_CHECKSUM_EN
        check("checksum_held", bus.checksum_out, 18'h00008);
`endif

        // Test 2: address wrap
        start_burst(10'h3FE, 11'd4);
        wait_done(40, "done_wrap");
        check("word_count_wrap", burst_pops, 4);

        // Test 3: len 16 with ready 1,0,0,1 and an ignored held start
        saw_gap = 0;
        toggle_mode = 1;
        start_burst(10'h080, 11'd16);
        repeat (4) @(posedge clk);
        #1;
        bus.base_addr_in = 10'h155;
        bus.len_in = 11'd5;
        bus.start_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.start_in = 1'b0;
        wait_done(300, "done_toggle");
        check("word_count_toggle", burst_pops, 16);
        check_true("credit_stall_seen", saw_gap);
        toggle_mode = 0;
        bus.ready_in = 1'b1;

        // Test 4: zero length
        zlen_window = 1;
        start_burst(10'h123, 11'd0);
        @(negedge clk);
        check("zlen_done", bus.done_out, 1'b1);
        check("zlen_busy", bus.busy_out, 1'b1);
        check("zlen_valid", bus.valid_out, 1'b0);
        check("zlen_en", bus.bram_en_out, 1'b0);
`ifdef BRAM_BURST_READER_CHECKSUM_EN
        check("zlen_checksum", bus.checksum_out, 18'h00000);
`endif
        @(negedge clk);
        check("zlen_done_gone", bus.done_out, 1'b0);
        check("zlen_busy_gone", bus.busy_out, 1'b0);
        @(posedge clk);
        #1;
        zlen_window = 0;

        // Test 5: reset while the 5th word of a len 10 burst is presented
        start_burst(10'h100, 11'd10);
        lat = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #2;
            if (burst_pops == 4 && bus.valid_out) begin
                lat = 1;
                break;
            end
        end
        check("reach_5th_word", lat, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("after_rst");
        start_burst(10'h200, 11'd3);
        wait_done(40, "done_after_reset");
        check("word_count_after_reset", burst_pops, 3);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
